// File: rtl/spi_link_pkg.sv
// Shared opcodes, FSM states, transfer kinds and status layout for the SPI link router.
package spi_link_pkg;

    localparam int LEN_W = 16;

    localparam logic [7:0] OP_DAC_WR     = 8'h87;
    localparam logic [7:0] OP_DAC_STREAM = 8'h88;
    localparam logic [7:0] OP_REG        = 8'h89;
    localparam logic [7:0] OP_REG_BURST  = 8'h8C;
    localparam logic [7:0] OP_STATUS     = 8'h8D;
    // FIFO opcodes carry the channel index in bits [1:0]
    localparam logic [5:0] OP_FIFO_WR_HI = 6'b100100;
    localparam logic [5:0] OP_FIFO_RD_HI = 6'b101000;

    localparam int ST_TIMEOUT  = 7;
    localparam int ST_UNDERRUN = 6;

    typedef enum logic [3:0] {
        IDLE, DAC_WR, ADDR, LEN_LO, LEN_HI, STREAM,
        REG_WR, REG_RD, FIFO_WR, FIFO_RD, DRAIN
    } state_t;

    typedef enum logic [2:0] {K_DAC, K_SGL, K_REG, K_FWR, K_FRD} kind_t;

endpackage

// File: rtl/spi_link_timeout.sv
// Idle-cycle watchdog: expires after TIMEOUT_CYC enabled cycles without a restart.
module spi_link_timeout #(
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic restart,
    output logic expire
);

    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || !enable || restart) cnt <= '0;
        else                           cnt <= cnt + CW'(1);
    end

    // a byte arriving on the expiry cycle wins over the abort
    assign expire = enable && !restart && (cnt == CW'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/spi_link_router.sv
// SPI command router: DAC, register-file and per-channel FIFO transfers from the PHY byte stream.
// Optional inter-byte timeout is enabled by defining SPI_LINK_TIMEOUT_EN.
module spi_link_router
    import spi_link_pkg::*;
#(
    parameter int         NUM_CH      = 2,
    parameter int         ADDR_W      = 7,
    parameter logic [7:0] FILL        = 8'h00,
    parameter int         TIMEOUT_CYC = 4096
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    output logic [7:0]            dac_state,
    output logic [ADDR_W-1:0]     reg_addr,
    output logic                  reg_we,
    output logic [7:0]            reg_wdata,
    input  logic [7:0]            reg_rdata,
    output logic [NUM_CH-1:0]     fifo_we,
    output logic [7:0]            fifo_wdata,
    input  logic [NUM_CH-1:0]     fifo_full,
    output logic [NUM_CH-1:0]     fifo_rd,
    input  logic [8*NUM_CH-1:0]   fifo_rdata,
    input  logic [NUM_CH-1:0]     fifo_empty,
    output logic                  busy
);

    state_t             state, state_next;
    kind_t              kind, kind_dec;
    logic               dir;
    logic [1:0]         ch;
    logic [LEN_W-1:0]   len, cnt, len_full;
    logic [ADDR_W-1:0]  addr;
    logic [NUM_CH-1:0]  overflow, ch_hot;
    logic               underrun, timeout_flag, expire;
    logic               full_c, empty_c, cnt_last, cnt_next_last;
    logic [7:0]         rdata_c, status;
    logic [3:0]         ovf4;
    logic               do_dac, do_reg_wr, do_reg_fetch, do_fifo_wr, do_fifo_fetch, do_status;

    assign busy          = (state != IDLE);
    assign len_full      = {rx_data, len[7:0]};
    assign cnt_last      = (cnt == len);
    assign cnt_next_last = (cnt + LEN_W'(1) == len);
    // single reads fetch on the address byte itself, so present it before it is registered
    assign reg_addr      = (state == ADDR && rx_valid) ? rx_data[ADDR_W-1:0] : addr;

    always_comb begin
        full_c  = 1'b0;
        empty_c = 1'b0;
        rdata_c = '0;
        ch_hot  = '0;
        ovf4    = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch == 2'(i)) begin
                ch_hot[i] = 1'b1;
                full_c    = fifo_full[i];
                empty_c   = fifo_empty[i];
                rdata_c   = fifo_rdata[8*i +: 8];
            end
            ovf4[i] = overflow[i];
        end
        status              = '0;
        status[ST_TIMEOUT]  = timeout_flag;
        status[ST_UNDERRUN] = underrun;
        status[3:0]         = ovf4;
    end

    always_comb begin
        state_next    = state;
        kind_dec      = K_DAC;
        do_dac        = 1'b0;
        do_reg_wr     = 1'b0;
        do_reg_fetch  = 1'b0;
        do_fifo_wr    = 1'b0;
        do_fifo_fetch = 1'b0;
        do_status     = 1'b0;
        if (rx_valid) begin
            case (state)
                IDLE: begin
                    if (rx_data == OP_DAC_WR) state_next = DAC_WR;
                    else if (rx_data == OP_DAC_STREAM) state_next = LEN_LO;
                    else if (rx_data == OP_REG) begin
                        kind_dec   = K_SGL;
                        state_next = ADDR;
                    end else if (rx_data == OP_REG_BURST) begin
                        kind_dec   = K_REG;
                        state_next = ADDR;
                    end else if (rx_data == OP_STATUS) do_status = 1'b1;
                    else if (rx_data[7:2] == OP_FIFO_WR_HI && int'(rx_data[1:0]) < NUM_CH) begin
                        kind_dec   = K_FWR;
                        state_next = LEN_LO;
                    end else if (rx_data[7:2] == OP_FIFO_RD_HI && int'(rx_data[1:0]) < NUM_CH) begin
                        kind_dec   = K_FRD;
                        state_next = LEN_LO;
                    end
                end
                DAC_WR: begin
                    do_dac     = 1'b1;
                    state_next = IDLE;
                end
                ADDR: begin
                    if (kind == K_REG) state_next = LEN_LO;
                    else if (rx_data[7]) state_next = REG_WR;
                    else begin
                        do_reg_fetch = 1'b1;
                        state_next   = REG_RD;
                    end
                end
                LEN_LO: state_next = LEN_HI;
                LEN_HI: begin
                    case (kind)
                        K_FWR:   state_next = FIFO_WR;
                        K_FRD: begin
                            do_fifo_fetch = 1'b1;
                            state_next    = (len_full == '0) ? DRAIN : FIFO_RD;
                        end
                        K_REG: begin
                            do_reg_fetch = !dir;
                            state_next   = (!dir && len_full == '0) ? DRAIN : STREAM;
                        end
                        default: state_next = STREAM;
                    endcase
                end
                STREAM: begin
                    if (kind == K_DAC || dir) begin
                        do_dac    = (kind == K_DAC);
                        do_reg_wr = (kind != K_DAC);
                        if (cnt_last) state_next = IDLE;
                    end else begin
                        do_reg_fetch = 1'b1;
                        if (cnt_next_last) state_next = DRAIN;
                    end
                end
                REG_WR: begin
                    do_reg_wr  = 1'b1;
                    state_next = IDLE;
                end
                FIFO_WR: begin
                    do_fifo_wr = 1'b1;
                    if (cnt_last) state_next = IDLE;
                end
                FIFO_RD: begin
                    do_fifo_fetch = 1'b1;
                    if (cnt_next_last) state_next = DRAIN;
                end
                REG_RD, DRAIN: state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
        if (expire) state_next = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            kind       <= K_DAC;
            dir        <= 1'b0;
            ch         <= '0;
            len        <= '0;
            cnt        <= '0;
            addr       <= '0;
            dac_state  <= '0;
            tx_data    <= '0;
            tx_valid   <= 1'b0;
            reg_we     <= 1'b0;
            reg_wdata  <= '0;
            fifo_we    <= '0;
            fifo_wdata <= '0;
            fifo_rd    <= '0;
            overflow   <= '0;
            underrun   <= 1'b0;
        end else begin
            state    <= state_next;
            tx_valid <= do_reg_fetch | do_fifo_fetch | do_status;
            reg_we   <= do_reg_wr;
            fifo_we  <= (do_fifo_wr && !full_c) ? ch_hot : '0;
            fifo_rd  <= (do_fifo_fetch && !empty_c) ? ch_hot : '0;
            if (do_reg_fetch)       tx_data <= reg_rdata;
            else if (do_fifo_fetch) tx_data <= empty_c ? FILL : rdata_c;
            else if (do_status)     tx_data <= status;
            if (do_dac)     dac_state  <= rx_data;
            if (do_reg_wr)  reg_wdata  <= rx_data;
            if (do_fifo_wr) fifo_wdata <= rx_data;
            if (rx_valid && state == IDLE) begin
                kind <= kind_dec;
                ch   <= rx_data[1:0];
            end
            if (rx_valid && state == LEN_LO) len[7:0] <= rx_data;
            if (rx_valid && state == LEN_HI) begin
                len[15:8] <= rx_data;
                cnt       <= '0;
            end else if (rx_valid && (state == STREAM || state == FIFO_WR || state == FIFO_RD)) begin
                cnt <= cnt + LEN_W'(1);
            end
            // burst writes step the address in the strobe cycle so it is stable while reg_we is high
            if (rx_valid && state == ADDR) begin
                addr <= rx_data[ADDR_W-1:0];
                dir  <= rx_data[7];
            end else if (kind == K_REG && (do_reg_fetch || reg_we)) begin
                addr <= addr + ADDR_W'(1);
            end
            overflow <= (do_status ? '0 : overflow) | ((do_fifo_wr && full_c) ? ch_hot : '0);
            underrun <= (underrun & ~do_status) | (do_fifo_fetch & empty_c);
        end
    end

`ifdef SPI_LINK_TIMEOUT_EN
    spi_link_timeout #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .enable (state != IDLE),
        .restart(rx_valid),
        .expire (expire)
    );

    always_ff @(posedge clk) begin
        if (rst) timeout_flag <= 1'b0;
        else     timeout_flag <= (timeout_flag & ~do_status) | expire;
    end
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYC == 0);
    assign expire         = 1'b0;
    assign timeout_flag   = 1'b0;
`endif

endmodule

// File: doc/spi_link_router.md
# spi_link_router

Parametrised SPI command router: decodes the byte stream from the SPI slave PHY into DAC writes, single/burst register-file accesses and burst transfers to/from `NUM_CH` FIFO channels, and returns read data to the PHY. It generalises the single-FIFO link state machine with length-prefixed bursts, per-channel FIFOs, auto-incrementing register bursts, flow-control status and an optional inter-byte timeout. It sits between the SPI slave PHY and the SD/audio register and FIFO fabric.

## Interface
- `NUM_CH`, 2: FIFO channel count, legal 1..4.
- `ADDR_W`, 7: register address width, legal 1..7.
- `FILL`, 8'h00: byte returned on read underrun.
- `TIMEOUT_CYC`, 4096: idle cycles before abort; only used with the timeout macro.
- Clock and reset: one clock, `clk`; reset `rst` is synchronous and active-high.
- `clk`  in  1  clock
- `rst`  in  1  synchronous active-high reset
- `rx_data`  in  8  byte from PHY
- `rx_valid`  in  1  one-cycle strobe; consecutive strobes are ≥2 cycles apart
- `tx_data`  out  8  registered byte to PHY
- `tx_valid`  out  1  one-cycle load strobe for `tx_data`
- `dac_state`  out  8  DAC test value
- `reg_addr`  out  ADDR_W  register address
- `reg_we`  out  1  one-cycle write strobe
- `reg_wdata`  out  8  register write data
- `reg_rdata`  in  8  asynchronous read of `reg_addr`
- `fifo_we`  out  NUM_CH  one-hot write strobe
- `fifo_wdata`  out  8  FIFO write data
- `fifo_full`  in  NUM_CH  per-channel full
- `fifo_rd`  out  NUM_CH  one-hot pop strobe
- `fifo_rdata`  in  8*NUM_CH  first-word-fall-through data, channel c at [8c+7:8c]
- `fifo_empty`  in  NUM_CH  per-channel empty
- `busy`  out  1  high whenever state ≠ IDLE

## Operation
- LEN is a 2-byte field, low byte first, holding count−1. A burst moves LEN+1 bytes; the counter is 16 bits.
- Opcodes are decoded in IDLE. Any other byte, or a channel index ≥ NUM_CH, is ignored and the block stays in IDLE.
  - 0x87: next byte → `dac_state`.
  - 0x88: LEN, then each body byte → `dac_state`.
  - 0x89: address byte. Bit7=1 is a write: the next byte is written to `reg_addr` = addr[ADDR_W-1:0]. Bit7=0 is a read: `reg_rdata` is returned and the following dummy byte ends the access.
  - 0x8C: address byte (bit7 = direction), then LEN, then LEN+1 data or dummy bytes. The address increments after each byte and wraps modulo 2^ADDR_W. A read returns each next byte as the current byte arrives. The last dummy byte triggers no fetch.
  - 0x8D: returns the status byte, then clears the sticky bits. Status = {timeout, underrun, 2'b00, overflow[3:0]}; unused overflow bits read 0.
  - 0x90|c: LEN, then LEN+1 bytes to channel c. If `fifo_full[c]` is set, the byte is dropped, no `fifo_we` is issued, and `overflow[c]` is set.
  - 0xA0|c: LEN, then LEN+1 dummy bytes. One byte is fetched after LEN-hi and one after each dummy except the last. If `fifo_empty[c]` is set, FILL is sent, no pop is issued, and `underrun` is set.
- States: IDLE, DAC_WR, ADDR, LEN_LO, LEN_HI, STREAM, REG_WR, REG_RD, FIFO_WR, FIFO_RD, DRAIN.
  - REG_RD and DRAIN consume the final dummy byte, then go to IDLE.
  - Bursts return to IDLE on the byte where count equals LEN.

## Timing
- Reset: all outputs 0, `dac_state`=0, state IDLE, counters 0, sticky bits 0. Reset mid-burst aborts the burst in one cycle and emits no strobe.
- Writes (`reg_we`, `fifo_we`): one-cycle pulse in cycle N+1 after `rx_valid` at N, with address/data stable in the same cycle.
- Reads: `tx_data`/`tx_valid` in cycle N+1. `fifo_rd` pulses in the same cycle as `tx_valid`, with data captured from the FWFT output.
- Status read: `tx_valid` at N+1, with bits cleared at N+1. A flag event in the same cycle as the clear leaves the flag set.
- The register address increment for a burst takes effect at N+1.

## Configuration
- `SPI_LINK_TIMEOUT_EN` defined:
  - In any state ≠ IDLE, TIMEOUT_CYC cycles without `rx_valid` force IDLE and set the `timeout` status bit.
  - `rx_valid` in the same cycle as expiry wins: the counter restarts and the byte is processed.
- Undefined: no timeout logic; status bit7 always reads 0.

## Structure
- `spi_link_pkg`: opcode constants, state enum, status bit indices, LEN width.
- Sub-module `spi_link_timeout` (cycle counter with restart/expire), instantiated only under `SPI_LINK_TIMEOUT_EN`.

## Test plan
- 0x87, 0x5A → `dac_state`=0x5A; `busy` low afterwards.
- 0x90, 0x02, 0x00, 0x11, 0x22, 0x33 on channel 0 → three `fifo_we[0]` pulses carrying 0x11/0x22/0x33. Repeat with `fifo_full[0]` held high → no writes; 0x8D returns 0x01, and a second 0x8D returns 0x00.
- Channel 1 preloaded with 0xA1, 0xA2; send 0xA1, LEN=0x0002, three dummies → `tx_data` sequence 0xA1, 0xA2, 0x00 with two pops; status = 0x40.
- 0x8C, 0xFE (write, addr 0x7E), LEN=0x0002, 0x01, 0x02, 0x03 at ADDR_W=7 → writes to 0x7E, 0x7F, 0x00.
- `rst` asserted after the second body byte of a 0x88 LEN=0x0009 stream → IDLE next cycle; a following 0x87, 0x33 → `dac_state`=0x33.
- With `SPI_LINK_TIMEOUT_EN`: send 0x88, then idle TIMEOUT_CYC cycles → IDLE; 0x8D returns 0x80.
